// File: rtl/nand_pattern_checker.sv
// -----------------------------------------------------------------------------
// nand_pattern_checker
//
// Stimulus and checking end for the 4-input NAND lab gate block. It walks
// all 16 input vectors {a,b,c,d} in order (a is the MSB). Each vector is held
// on drv_* for SETTLE_CYCLES clocks. The DUT outputs are then sampled for one
// cycle and compared against a golden model of the gate network:
//    ey = ~(a & b & c & d)
//    ee = ~(a & b)
//    ef = ~(ee & c)
//    eg = ~(ee & ef)
// Failing vectors are counted, mismatching bits are OR-accumulated, and the
// first failing vector is captured.
//
// Parameters
//    SETTLE_CYCLES  clocks a vector is driven before it is checked (1..15)
//
// Ports
//    clk               system clock, rising edge
//    rst               synchronous active-high reset
//    start             starts a sweep when seen in IDLE or DONE (pulse or level)
//    drv_a..drv_d      stimulus to DUT inputs a..d (0 outside a sweep)
//    dut_y..dut_g      DUT outputs y, e, f, g
//    busy              sweep in progress
//    done              sweep finished; results valid and held
//    pass              done with no failing vector
//    err_count         number of failing vectors (0..16)
//    fail_bits         sticky OR of mismatching bits, order {y,e,f,g}
//    first_fail_valid  at least one vector has failed
//    first_fail_vec    {a,b,c,d} of the first failing vector
//
// State    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | out of reset, waiting for start; all outputs 0
// ST_DRIVE | vec on drv_*, settle timer counting down to 0
// ST_CHECK | one cycle: compare DUT outputs with golden model, advance vec
// ST_DONE  | sweep complete, results held; start begins a new sweep
// -----------------------------------------------------------------------------
module nand_pattern_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       drv_a,
    output logic       drv_b,
    output logic       drv_c,
    output logic       drv_d,
    input  logic       dut_y,
    input  logic       dut_e,
    input  logic       dut_f,
    input  logic       dut_g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] fail_bits,
    output logic       first_fail_valid,
    output logic [3:0] first_fail_vec
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range_err
        $error("nand_pattern_checker: SETTLE_CYCLES=%0d outside 1..15", SETTLE_CYCLES);
    end

    // Settle timer is a down-counter loaded with SETTLE_CYCLES-1 and
    // compared against 0, giving exactly SETTLE_CYCLES cycles in DRIVE.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] vec;
    logic [3:0] settle_cnt;
    logic [3:0] drv_vec;

    logic       exp_y;
    logic       exp_e;
    logic       exp_f;
    logic       exp_g;
    logic [3:0] expected;
    logic [3:0] observed;
    logic [3:0] mism;

    always_comb begin
        exp_y    = ~(vec[3] & vec[2] & vec[1] & vec[0]);
        exp_e    = ~(vec[3] & vec[2]);
        exp_f    = ~(exp_e & vec[1]);
        exp_g    = ~(exp_e & exp_f);
        expected = {exp_y, exp_e, exp_f, exp_g};
        observed = {dut_y, dut_e, dut_f, dut_g};
        mism     = observed ^ expected;
    end

    assign {drv_a, drv_b, drv_c, drv_d} = drv_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            vec              <= 4'd0;
            settle_cnt       <= 4'd0;
            drv_vec          <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 5'd0;
            fail_bits        <= 4'd0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state            <= ST_DRIVE;
                        vec              <= 4'd0;
                        settle_cnt       <= SETTLE_LOAD;
                        drv_vec          <= 4'd0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= 5'd0;
                        fail_bits        <= 4'd0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= 4'd0;
                    end
                end

                ST_DRIVE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                ST_CHECK: begin
                    if (mism != 4'd0) begin
                        err_count <= err_count + 5'd1;
                        fail_bits <= fail_bits | mism;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec;
                        end
                    end
                    if (vec == 4'd15) begin
                        state   <= ST_DONE;
                        drv_vec <= 4'd0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // err_count has not yet absorbed this vector's result
                        pass    <= (err_count == 5'd0) && (mism == 4'd0);
                    end else begin
                        state      <= ST_DRIVE;
                        vec        <= vec + 4'd1;
                        drv_vec    <= vec + 4'd1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_nand_pattern_checker
//
// Two checkers share the clock: dut0 at the default SETTLE_CYCLES=2 and dut1
// at SETTLE_CYCLES=1. Each is connected to a behavioural model of the NAND lab
// block that can carry faults (y stuck at 0, g inverted, e wrong at vector 12,
// or a random per-vector flip table). Every issued start pushes the expected
// sweep result into a queue. A monitor pops that entry when done rises and
// compares it, together with the cycle on which done appeared.
// -----------------------------------------------------------------------------
module tb_nand_pattern_checker;

    typedef struct {
        int err;
        int fb;
        int ffv;
        int ffvec;
        int done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    logic       rst0, start0, rst1, start1;
    logic       a0, b0, c0, d0, a1, b1, c1, d1;
    logic [3:0] drv0, drv1, resp0, resp1;
    logic       busy0, done0, pass0, ffv0, busy1, done1, pass1, ffv1;
    logic [4:0] err0, err1;
    logic [3:0] fb0, ffvec0, fb1, ffvec1;

    int         mode0 = 0;
    int         mode1 = 0;
    logic [3:0] flip0 [16];
    logic [3:0] flip1 [16];

    exp_t q0[$];
    exp_t q1[$];

    assign drv0 = {a0, b0, c0, d0};
    assign drv1 = {a1, b1, c1, d1};

    nand_pattern_checker #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst0), .start(start0),
        .drv_a(a0), .drv_b(b0), .drv_c(c0), .drv_d(d0),
        .dut_y(resp0[3]), .dut_e(resp0[2]), .dut_f(resp0[1]), .dut_g(resp0[0]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_bits(fb0), .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
    );

    nand_pattern_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1),
        .drv_a(a1), .drv_b(b1), .drv_c(c1), .drv_d(d1),
        .dut_y(resp1[3]), .dut_e(resp1[2]), .dut_f(resp1[1]), .dut_g(resp1[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_bits(fb1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
    );

    // Gate block as built on the board, with optional faults.
    function automatic logic [3:0] dut_resp(input logic [3:0] v, input int mode,
                                            input logic [3:0] flip);
        logic y, e, f, g;
        logic [3:0] r;
        y = ~(v[3] & v[2] & v[1] & v[0]);
        e = ~(v[3] & v[2]);
        if (mode == 3 && v == 4'd12) e = 1'b1;
        f = ~(e & v[1]);
        g = ~(e & f);
        r = {y, e, f, g};
        if (mode == 1) r[3] = 1'b0;
        if (mode == 2) r[0] = ~r[0];
        if (mode == 4) r = r ^ flip;
        return r;
    endfunction

    // Golden response from the truth table: a&b is vectors 12..15,
    // a&b&c&d is vector 15 only.
    function automatic logic [3:0] golden(input int v);
        logic ey, ee, ef, eg;
        ey = (v != 15);
        ee = (v < 12);
        ef = !(ee && ((v / 2) % 2 == 1));
        eg = !(ee && ef);
        return {ey, ee, ef, eg};
    endfunction

    function automatic exp_t predict(input int d, input int mode);
        exp_t e;
        logic [3:0] m, fl;
        e = '{0, 0, 0, 0, 0};
        for (int v = 0; v < 16; v++) begin
            fl = (d == 0) ? flip0[v] : flip1[v];
            m  = dut_resp(4'(v), mode, fl) ^ golden(v);
            if (m != 4'd0) begin
                e.err++;
                e.fb = e.fb | int'(m);
                if (e.ffv == 0) begin
                    e.ffv   = 1;
                    e.ffvec = v;
                end
            end
        end
        return e;
    endfunction

    always_comb resp0 = dut_resp(drv0, mode0, flip0[drv0]);
    always_comb resp1 = dut_resp(drv1, mode1, flip1[drv1]);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_result(input exp_t e, input int err, input int fb, input int ffv,
                                input int ffvec, input int pass, input int busy);
        chk("err_count", err, e.err);
        chk("fail_bits", fb, e.fb);
        chk("first_fail_valid", ffv, e.ffv);
        chk("first_fail_vec", ffvec, e.ffvec);
        chk("pass", pass, (e.err == 0) ? 1 : 0);
        chk("busy_in_done", busy, 0);
        chk("done_cycle", cyc, e.done_cyc);
    endtask

    // Monitors: a rising done must match the oldest pending expectation.
    logic done0_q = 1'b0;
    logic done1_q = 1'b0;

    always @(negedge clk) begin
        if (done0 && !done0_q) begin
            if (q0.size() == 0) chk("dut0_unexpected_done", 1, 0);
            else check_result(q0.pop_front(), int'(err0), int'(fb0), int'(ffv0),
                              int'(ffvec0), int'(pass0), int'(busy0));
        end
        done0_q = done0;
        if (done1 && !done1_q) begin
            if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
            else check_result(q1.pop_front(), int'(err1), int'(fb1), int'(ffv1),
                              int'(ffvec1), int'(pass1), int'(busy1));
        end
        done1_q = done1;
    end

    // One sweep: pulse start, push expectation, optionally check drv stepping
    // and inject a stray start at loop index extra_at (-1 for none).
    task automatic sweep(input int d, input int mode, input exp_t e,
                         input bit chk_drv, input int extra_at);
        int per;
        bit seen;
        per = (d == 0) ? 3 : 2;
        @(negedge clk);
        if (d == 0) begin mode0 = mode; start0 = 1'b1; end
        else        begin mode1 = mode; start1 = 1'b1; end
        @(posedge clk);
        #1;
        e.done_cyc = cyc + 16 * per;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        seen = 1'b0;
        for (int k = 1; k <= 16 * per + 20 && !seen; k++) begin
            @(negedge clk);
            if (d == 0) start0 = (k == extra_at);
            else        start1 = (k == extra_at);
            if (chk_drv && k <= 16 * per)
                chk("drv_step", (d == 0) ? int'(drv0) : int'(drv1), (k - 1) / per);
            if ((d == 0) ? done0 : done1) seen = 1'b1;
        end
        if (d == 0) start0 = 1'b0; else start1 = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_done0();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   m;
        for (int v = 0; v < 16; v++) begin
            flip0[v] = 4'd0;
            flip1[v] = 4'd0;
        end
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_fail_bits", int'(fb0), 0);
        chk("rst_ffv", int'(ffv0), 0);
        chk("rst_drv", int'(drv0), 0);
        chk("rst_dut1_busy", int'(busy1), 0);
        rst0 = 1'b0; rst1 = 1'b0;

        // Directed sweeps with expectations taken from the known fault effects.
        sweep(0, 0, '{0, 0, 0, 0, 0}, 1'b1, -1);
        sweep(0, 1, '{15, 8, 1, 0, 0}, 1'b0, -1);
        sweep(0, 2, '{16, 1, 1, 0, 0}, 1'b0, -1);
        sweep(0, 3, '{1, 5, 1, 12, 0}, 1'b0, -1);
        sweep(0, 0, '{0, 0, 0, 0, 0}, 1'b1, 10);
        sweep(0, 1, '{15, 8, 1, 0, 0}, 1'b0, 30);

        // Start held high in DONE restarts with cleared results.
        @(negedge clk);
        mode0  = 0;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        q0.push_back('{0, 0, 0, 0, cyc + 48});
        chk("restart_done", int'(done0), 0);
        chk("restart_err", int'(err0), 0);
        chk("restart_fail_bits", int'(fb0), 0);
        chk("restart_busy", int'(busy0), 1);
        @(negedge clk);
        start0 = 1'b0;
        wait_done0();

        // Reset during the CHECK cycle of vector 7 discards the sweep.
        @(negedge clk);
        mode0  = 1;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (23) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_vec", int'(drv0), 7);
        chk("pre_rst_err", int'(err0), 7);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", int'(busy0), 0);
        chk("mid_rst_drv", int'(drv0), 0);
        chk("mid_rst_err", int'(err0), 0);
        chk("mid_rst_done", int'(done0), 0);
        @(negedge clk);
        rst0 = 1'b0;
        sweep(0, 0, '{0, 0, 0, 0, 0}, 1'b0, -1);

        // rst and start together: rst wins.
        @(negedge clk);
        rst0   = 1'b1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_start_busy", int'(busy0), 0);
        chk("rst_start_done", int'(done0), 0);
        @(negedge clk);
        rst0   = 1'b0;
        start0 = 1'b0;

        // SETTLE_CYCLES=1 instance.
        sweep(1, 0, '{0, 0, 0, 0, 0}, 1'b1, -1);
        sweep(1, 3, '{1, 5, 1, 12, 0}, 1'b0, -1);

        // Randomized fault patterns against the reference model.
        for (int i = 0; i < 10; i++) begin
            m = int'($urandom_range(0, 4));
            for (int v = 0; v < 16; v++) begin
                flip0[v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                flip1[v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            end
            e = predict(i % 2, m);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            sweep(i % 2, m, e, 1'b0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1);
        end

        repeat (5) @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
